jk_drive_seq: RTL
=================

# jk_drive_seq

Command-driven excitation generator that sits in front of a bank of WIDTH JK flip-flop cells and is the driving end of their J/K interface. It accepts LOAD/INC/DEC/TOGGLE commands over a valid/ready handshake and derives per-bit J/K excitation from the bank's fed-back Q. It drives J/K for exactly one clock per command, then checks that the bank landed on the expected value. Mismatches are reported as an error pulse and counted.

## Interface
- WIDTH, 4, number of JK cells driven (1..16)
- ERRW, 8, width of the saturating error counter
- clk  input  1  rising-edge clock
- n_rst  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept; high only in IDLE
- cmd_op  input  2  0=LOAD, 1=INC, 2=DEC, 3=TOGGLE
- cmd_data  input  WIDTH  LOAD value or TOGGLE mask; ignored for INC/DEC
- q_fb  input  WIDTH  Q outputs of the JK bank
- din_j  output  WIDTH  J inputs to the bank (registered)
- din_k  output  WIDTH  K inputs to the bank (registered)
- busy  output  1  high in DRIVE or CHECK
- err  output  1  one-cycle mismatch pulse (registered)
- err_cnt  output  ERRW  saturating mismatch count

## Operation
- FSM states: IDLE, DRIVE, CHECK.
  - IDLE -> DRIVE on cmd_valid && cmd_ready.
  - DRIVE -> CHECK unconditionally.
  - CHECK -> IDLE unconditionally.
- At accept, the block captures cur = q_fb and computes the expected value exp:
  - LOAD: exp = cmd_data.
  - INC: exp = cur + 1, modulo 2^WIDTH (all-ones wraps to 0).
  - DEC: exp = cur - 1, modulo 2^WIDTH (0 wraps to all-ones).
  - TOGGLE: exp = cur ^ cmd_data.
- Excitation per bit (cur -> exp) for LOAD/INC/DEC:
  - 0->0: J=0, K=0.
  - 0->1: J=1, K=0.
  - 1->0: J=0, K=1.
  - 1->1: J=0, K=0.
  - J=K=1 is never produced for these ops.
- TOGGLE: din_j = din_k = cmd_data.
  - Bits outside the mask get J=K=0.
  - A zero mask is legal: nothing changes, and the check passes if Q held.
- din_j/din_k equal the computed values only while in DRIVE; they are all-zero in every other state.
- In CHECK, the block compares q_fb with exp.
  - Mismatch: err pulses high for one cycle and err_cnt increments, saturating at 2^ERRW-1.
  - Match: err = 0.
- cmd_valid while not ready: the command is not consumed. The source holds cmd_op and cmd_data stable until accepted.
- Reset values: state IDLE, din_j=0, din_k=0, err=0, err_cnt=0, exp/cur regs=0. cmd_ready=1 and busy=0 (both decoded from state).
- Reset asserted mid-operation: J/K return to 0 immediately (async) and the command is dropped. No err is generated.

## Timing
- E0 = accept edge.
- din_j/din_k valid from E0 to E1; the bank updates at E1.
- q_fb is compared in the CHECK cycle; err is registered at E2 and visible for the one cycle after E2.
- cmd_ready returns high after E2, so err overlaps the first IDLE cycle.
- Throughput: one command per 3 cycles. A back-to-back cmd_valid is accepted at E3.
- q_fb must settle combinationally from the bank's Q before E2 (no extra sync stage; the bank is on clk).
- cmd_ready and busy are combinational from state only, with no path from cmd_valid.

## Structure
- Package jk_drive_pkg:
  - op encodings OP_LOAD/OP_INC/OP_DEC/OP_TOGGLE.
  - FSM state enum ST_IDLE/ST_DRIVE/ST_CHECK.
- Sub-module jk_excite: purely combinational, 1-bit, cur/nxt -> j/k per the excitation list above.
  - Instantiated WIDTH times via generate.
  - TOGGLE override muxed in the parent.
- Bench model: WIDTH behavioural JK cells on clk/n_rst with reset Q=0. Q=0 feeds q_fb; set/reset/toggle/hold semantics.

## Test plan
- Reset, then LOAD 4'hA: din_j=4'hA, din_k=0 for one cycle; q_fb=4'hA at CHECK; err=0; err_cnt=0.
- Q=4'hF, INC: wraps to 4'h0 (din_j=0, din_k=4'hF). Q=4'h0, DEC: wraps to 4'hF. Both err=0.
- Q=4'h5, TOGGLE mask 4'h6: din_j=din_k=4'h6 for one cycle; Q=4'h3; err=0. Mask 4'h0: Q unchanged, no J/K activity.
- Fault injection: force bit 2 of q_fb low during CHECK after LOAD 4'hF. Required: err pulses once and err_cnt=1. Run 300 faults with ERRW=8: err_cnt saturates at 255.
- cmd_valid held high continuously with alternating INC/LOAD 4'h3: accepts exactly every 3rd cycle, cmd_ready low for 2 cycles after each accept, no command lost or repeated.
- n_rst asserted in DRIVE after LOAD 4'hC: din_j/din_k drop to 0 without waiting for clk; state IDLE; err and err_cnt remain 0; the next LOAD 4'h1 after release completes normally.

Source files
------------

// File: rtl/jk_drive_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jk_drive_pkg : shared command opcodes and FSM states for jk_drive_seq |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package jk_drive_pkg;

   typedef enum logic [1:0] {
      OP_LOAD   = 2'd0,
      OP_INC    = 2'd1,
      OP_DEC    = 2'd2,
      OP_TOGGLE = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/jk_drive_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jk_drive_seq_if : command handshake plus J/K bank bus                 |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface jk_drive_seq_if
   import jk_drive_pkg::*;
#(
   parameter int WIDTH = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   op_e              cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [WIDTH-1:0] q_fb;
   logic [WIDTH-1:0] din_j;
   logic [WIDTH-1:0] din_k;

   // master is the command source together with the JK bank it fronts
   modport master (
      output cmd_valid, cmd_op, cmd_data, q_fb,
      input  cmd_ready, din_j, din_k
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, q_fb,
      output cmd_ready, din_j, din_k
   );
endinterface
`default_nettype wire

// File: rtl/jk_drive_seq_excite.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jk_excite : 1-bit JK excitation, current/next state -> J/K            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module jk_excite (
   input  wire  i_cur,
   input  wire  i_nxt,
   output logic o_j,
   output logic o_k
);
   // Hold-style excitation only; J=K=1 is never emitted
   always_comb begin
      o_j = 1'b0;
      o_k = 1'b0;
      case ({i_cur, i_nxt})
         2'b01:   o_j = 1'b1;
         2'b10:   o_k = 1'b1;
         default: begin
            o_j = 1'b0;
            o_k = 1'b0;
         end
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/jk_drive_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jk_drive_seq : command-driven J/K excitation with landing check       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module jk_drive_seq
   import jk_drive_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int ERRW  = 8
) (
   input  wire              clk,
   input  wire              n_rst,
   jk_drive_seq_if.slave    bus,
   output logic             busy,
   output logic             err,
   output logic [ERRW-1:0]  err_cnt
);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [WIDTH-1:0] r_exp;
   logic [WIDTH-1:0] r_din_j;
   logic [WIDTH-1:0] r_din_k;
   logic             r_err;
   logic [ERRW-1:0]  r_err_cnt;

   logic             w_accept;
   logic             w_mismatch;
   logic [WIDTH-1:0] w_exp;
   logic [WIDTH-1:0] w_jx;
   logic [WIDTH-1:0] w_kx;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;

   assign bus.cmd_ready = (r_state == ST_IDLE);
   assign busy          = (r_state != ST_IDLE);
   assign w_accept      = bus.cmd_valid && (r_state == ST_IDLE);
   assign w_mismatch    = (r_state == ST_CHECK) && (bus.q_fb != r_exp);

   always_comb begin
      w_exp = bus.cmd_data;
      case (bus.cmd_op)
         OP_LOAD:   w_exp = bus.cmd_data;
         OP_INC:    w_exp = bus.q_fb + WIDTH'(1);
         OP_DEC:    w_exp = bus.q_fb - WIDTH'(1);
         OP_TOGGLE: w_exp = bus.q_fb ^ bus.cmd_data;
         default:   w_exp = bus.cmd_data;
      endcase
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      jk_excite u_excite (
         .i_cur (bus.q_fb[gi]),
         .i_nxt (w_exp[gi]),
         .o_j   (w_jx[gi]),
         .o_k   (w_kx[gi])
      );
   end

   // TOGGLE drives the raw mask on both J and K so masked bits flip in place
   assign w_j = (bus.cmd_op == OP_TOGGLE) ? bus.cmd_data : w_jx;
   assign w_k = (bus.cmd_op == OP_TOGGLE) ? bus.cmd_data : w_kx;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept) w_state_nxt = ST_DRIVE;
         ST_DRIVE: w_state_nxt = ST_CHECK;
         ST_CHECK: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // J/K are only non-zero for the single DRIVE cycle following accept
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_exp     <= '0;
         r_din_j   <= '0;
         r_din_k   <= '0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_err <= w_mismatch;
         if (w_accept) begin
            r_exp   <= w_exp;
            r_din_j <= w_j;
            r_din_k <= w_k;
         end else begin
            r_din_j <= '0;
            r_din_k <= '0;
         end
         if (w_mismatch && (r_err_cnt != {ERRW{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERRW'(1);
         end
      end
   end

   assign bus.din_j = r_din_j;
   assign bus.din_k = r_din_k;
   assign err       = r_err;
   assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire
